// File: rtl/uart_tx_scheduler.sv
// Single owner of the TX FIFO write port: arbitrates command-character echo
// against HH:MM:SS[\r\n] time-report frames without interleaving messages.
module uart_tx_scheduler #(
    parameter logic [7:0] SEP_CHAR = 8'h3A,
    parameter bit         CRLF_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo_valid,
    input  logic [7:0] echo_data,
    input  logic       report_req,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       echo_drop
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ECHO   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [3:0] LAST_IDX = CRLF_EN ? 4'd9 : 4'd7;

    logic [1:0]      state_reg, state_next;
    logic [3:0]      idx_reg, idx_next;
    logic            echo_pend_reg, echo_pend_next;
    logic [7:0]      echo_buf_reg, echo_buf_next;
    logic            report_pend_reg, report_pend_next;
    logic [2:0][5:0] snap_reg, snap_next;
    logic [7:0]      tx_data_reg, tx_data_next;
    logic            echo_drop_reg, echo_drop_next;

    logic [2:0][7:0] tens_byte;
    logic [2:0][7:0] ones_byte;
    logic [5:0]      live_hour;
    logic [7:0]      live_hour_tens;
    logic [3:0]      idx_plus;
    logic [7:0]      next_byte;
    logic            echo_consumed;

    // Snapshot fields: 0 = hour, 1 = minute, 2 = second; encoded unclamped.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digits
            assign tens_byte[gi] = {4'h3, 4'(snap_reg[gi] / 6'd10)};
            assign ones_byte[gi] = {4'h3, 4'(snap_reg[gi] % 6'd10)};
        end
    endgenerate

    assign live_hour      = {1'b0, i_hour};
    assign live_hour_tens = {4'h3, 4'(live_hour / 6'd10)};

    assign tx_push       = ((state_reg == ST_ECHO) || (state_reg == ST_REPORT)) && !tx_full;
    assign tx_data       = tx_data_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign echo_drop     = echo_drop_reg;
    assign echo_consumed = (state_reg == ST_ECHO) && tx_push;
    assign idx_plus      = idx_reg + 4'd1;

    always_comb begin
        next_byte = tens_byte[0];
        case (idx_plus)
            4'd1:    next_byte = ones_byte[0];
            4'd2:    next_byte = SEP_CHAR;
            4'd3:    next_byte = tens_byte[1];
            4'd4:    next_byte = ones_byte[1];
            4'd5:    next_byte = SEP_CHAR;
            4'd6:    next_byte = tens_byte[2];
            4'd7:    next_byte = ones_byte[2];
            4'd8:    next_byte = 8'h0D;
            4'd9:    next_byte = 8'h0A;
            default: next_byte = tens_byte[0];
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        echo_pend_next   = echo_pend_reg;
        echo_buf_next    = echo_buf_reg;
        report_pend_next = report_pend_reg;
        snap_next        = snap_reg;
        tx_data_next     = tx_data_reg;
        echo_drop_next   = 1'b0;

        // A byte arriving on the cycle the old one leaves reuses the slot.
        if (echo_consumed) begin
            echo_pend_next = 1'b0;
        end
        if (echo_valid) begin
            if (!echo_pend_reg || echo_consumed) begin
                echo_pend_next = 1'b1;
                echo_buf_next  = echo_data;
            end else begin
                echo_drop_next = 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (echo_pend_reg) begin
                    state_next   = ST_ECHO;
                    tx_data_next = echo_buf_reg;
                end else if (report_pend_reg) begin
                    state_next       = ST_REPORT;
                    idx_next         = 4'd0;
                    report_pend_next = 1'b0;
                    snap_next[0]     = live_hour;
                    snap_next[1]     = i_min;
                    snap_next[2]     = i_sec;
                    tx_data_next     = live_hour_tens;
                end
            end
            ST_ECHO: begin
                if (tx_push) begin
                    state_next = ST_IDLE;
                end
            end
            ST_REPORT: begin
                if (tx_push) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next     = idx_plus;
                        tx_data_next = next_byte;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Set after the IDLE->REPORT clear so a request during a frame queues another.
        if (report_req) begin
            report_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= 4'd0;
            echo_pend_reg   <= 1'b0;
            echo_buf_reg    <= 8'h00;
            report_pend_reg <= 1'b0;
            snap_reg        <= '0;
            tx_data_reg     <= 8'h00;
            echo_drop_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            echo_pend_reg   <= echo_pend_next;
            echo_buf_reg    <= echo_buf_next;
            report_pend_reg <= report_pend_next;
            snap_reg        <= snap_next;
            tx_data_reg     <= tx_data_next;
            echo_drop_reg   <= echo_drop_next;
        end
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Sequences the UART transmit path. It shares the single TX FIFO write port between two requesters:
- Echo of received command characters.
- Formatted time-report frames "HH:MM:SS\r\n" built from the stopwatch/watch counters.
It sits between the command unit / time core and the uart_top TX FIFO. It owns all TX FIFO pushes, holds off on FIFO full, and never interleaves bytes of different messages.

Parameters:
SEP_CHAR, 8'h3A, ASCII separator between HH, MM and SS fields.
CRLF_EN, 1, 1 = append 8'h0D 8'h0A (10-byte frame); 0 = 8-byte frame.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
echo_valid  input  1  one-cycle pulse: echo_data is a byte to echo
echo_data  input  8  byte to echo
report_req  input  1  one-cycle pulse: request one time-report frame
i_hour  input  5  current hour, 0-23
i_min  input  6  current minute, 0-59
i_sec  input  6  current second, 0-59
tx_full  input  1  TX FIFO full
tx_push  output  1  TX FIFO write strobe
tx_data  output  8  TX FIFO write data
busy  output  1  high while state != IDLE
echo_drop  output  1  one-cycle pulse: an echo byte was discarded

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; echo_pend=0; report_pend=0; byte index=0.
  - echo_drop=0; busy=0; tx_push=0; tx_data=8'h00.
  - Reset mid-frame abandons the frame; no further bytes of it are pushed.
- Echo buffer: one entry (echo_pend, echo_buf).
  - echo_valid with echo_pend=0: capture echo_data, set echo_pend.
  - echo_valid with echo_pend=1 and not consumed that cycle: drop the new byte; echo_drop=1 for one cycle, registered, next cycle. The old byte is kept.
- Report request: report_pend is set by report_req.
  - Any number of report_req pulses while pending merge into one frame.
  - A report_req arriving during REPORT sets report_pend again, giving exactly one more frame afterwards.
- States: IDLE, ECHO, REPORT.
  - IDLE -> ECHO when echo_pend=1. Echo has priority over report.
  - IDLE -> REPORT when echo_pend=0 and report_pend=1.
    - On this transition: snapshot i_hour/i_min/i_sec, clear report_pend, index=0.
  - ECHO -> IDLE when the push occurs; echo_pend is cleared on the same edge.
  - REPORT stays until the last byte is pushed (index 7, or 9 with CRLF_EN=1), then -> IDLE.
    - Echo bytes arriving during REPORT wait in echo_pend and are sent after the frame.
- Push handshake:
  - tx_push = (state==ECHO || state==REPORT) && !tx_full. Combinational from registered state and tx_full.
  - tx_data is driven from registers and is valid whenever tx_push=1.
  - A byte advances (index++, or echo completes) only on an edge where tx_push=1.
  - While tx_full=1: tx_push=0; state, index and data are held indefinitely, with no byte loss or duplication.
- Frame bytes, from the snapshot:
  - Byte 0/1: 8'h30+hour/10, 8'h30+hour%10.
  - Byte 2: SEP_CHAR.
  - Bytes 3/4: minute tens/ones.
  - Byte 5: SEP_CHAR.
  - Bytes 6/7: second tens/ones.
  - Bytes 8/9: 8'h0D, 8'h0A (only when CRLF_EN=1).
  - Inputs are always encoded as two digits (tens 0-6). Out-of-range values such as 60-63 are encoded as-is, not clamped.
- Timing:
  - A request seen in IDLE enters its state on the next edge.
  - First push is in the cycle after that, if tx_full=0.
  - A full frame with tx_full=0 occupies 10 consecutive push cycles (CRLF_EN=1).
- Simultaneous echo_valid and report_req in IDLE: the echo is sent first, then the report.

Test Plan:
1. Reset with all inputs 0 -> tx_push=0, busy=0, echo_drop=0 for 20 cycles. Then echo_valid with 8'h41 -> exactly one tx_push with tx_data=8'h41 two cycles later, then busy=0.
2. i_hour=13, i_min=5, i_sec=59, report_req pulse, tx_full=0 -> 10 consecutive pushes: 31 33 3A 30 35 3A 35 39 0D 0A. Change inputs to 0 after the first push -> frame bytes unchanged (snapshot).
3. During scenario 2, hold tx_full=1 for 5 cycles after the 4th byte -> no push during the stall. Byte 5 (8'h35) is pushed once, and the sequence is otherwise identical.
4. echo_valid 8'h61 on the cycle report_req pulses -> 8'h61 pushed first, then the full frame. A second echo_valid (8'h62) during the frame -> pushed right after 8'h0A. A third echo_valid (8'h63) while 8'h62 is pending -> echo_drop pulse, and 8'h63 is never pushed.
5. Three report_req pulses within one frame -> exactly two frames in total.
6. rst=1 at byte index 4 of a frame -> next cycle tx_push=0, busy=0. report_req afterwards starts a fresh frame at byte 0.
